// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings, baud table and divisor math.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int unsigned BAUD_CODE_W = 3;
    localparam int unsigned PAR_MODE_W  = 2;

    localparam logic [PAR_MODE_W-1:0] PAR_NONE     = 2'b00;
    localparam logic [PAR_MODE_W-1:0] PAR_EVEN     = 2'b01;
    localparam logic [PAR_MODE_W-1:0] PAR_ODD      = 2'b10;
    localparam logic [PAR_MODE_W-1:0] PAR_NONE_ALT = 2'b11;

    // Baud rate in bit/s for each 3-bit select code.
    function automatic int unsigned baud_rate(input logic [BAUD_CODE_W-1:0] code);
        int unsigned rate;
        case (code)
            3'd0:    rate = 300;
            3'd1:    rate = 1200;
            3'd2:    rate = 4800;
            3'd3:    rate = 9600;
            3'd4:    rate = 19200;
            3'd5:    rate = 38400;
            3'd6:    rate = 57600;
            default: rate = 115200;
        endcase
        return rate;
    endfunction

    // Clock cycles per baud tick, rounded to nearest; never below 1.
    function automatic int unsigned baud_divisor(input int unsigned          clk_freq,
                                                 input int unsigned          oversample,
                                                 input logic [BAUD_CODE_W-1:0] code);
        int unsigned den;
        int unsigned div;
        den = oversample * baud_rate(code);
        div = (clk_freq + (den / 2)) / den;
        if (div == 0) begin
            div = 1;
        end
        return div;
    endfunction

    function automatic logic parity_enabled(input logic [PAR_MODE_W-1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle registered tick every divisor clocks for the selected code.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [BAUD_CODE_W-1:0] code,
    output logic                   tick
);

    localparam int unsigned DIV_W = 32;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] div_last;
    logic             tick_q;
    logic             tick_d;

    // Divider wraps at divisor-1 and raises the tick; clear restarts the phase.
    always_comb begin
        div_last = DIV_W'(baud_divisor(CLK_FREQ, OVERSAMPLE, code) - 1);
        div_d    = div_q + DIV_W'(1);
        tick_d   = 1'b0;
        if (clear) begin
            div_d = '0;
        end else if (div_q >= div_last) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Divider and tick registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with ready/valid input and per-frame parity/baud latching.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BAUD_CODE_W-1:0] baud_select,
    input  logic [PAR_MODE_W-1:0]  parity_mode,
    input  logic                   tx_en,
    input  logic                   tx_valid,
    input  logic [DATA_W-1:0]      tx_data,
    output logic                   tx_ready,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   TxD
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

    tx_state_e               state_q, state_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [PAR_MODE_W-1:0]   par_mode_q, par_mode_d;
    logic                    par_bit_q, par_bit_d;
    logic [BAUD_CODE_W-1:0]  baud_q, baud_d;
    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    baud_tick;
    logic                    bit_end;

    assign tx_ready = (state_q == IDLE) && tx_en && !reset;
    assign accept   = tx_valid && tx_ready;

    // Tick source restarts at acceptance so the first bit is full length.
    uart_baud_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .code  (baud_q),
        .tick  (baud_tick)
    );

    // Next-state logic; TxD is updated on the same edge the state advances.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_mode_d = par_mode_q;
        par_bit_d  = par_bit_q;
        baud_d     = baud_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bit_end    = 1'b0;

        if ((state_q != IDLE) && baud_tick) begin
            if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                tick_cnt_d = '0;
                bit_end    = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    state_d    = START;
                    data_d     = tx_data;
                    par_mode_d = parity_mode;
                    par_bit_d  = (^tx_data) ^ (parity_mode == PAR_ODD);
                    baud_d     = baud_select;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    state_d   = DATA;
                    txd_d     = data_q[0];
                    data_d    = {1'b0, data_q[DATA_W-1:1]};
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        if (parity_enabled(par_mode_q)) begin
                            state_d = PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d     = data_q[0];
                        data_d    = {1'b0, data_q[DATA_W-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    txd_d     = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            par_mode_q <= PAR_NONE;
            par_bit_q  <= 1'b0;
            baud_q     <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_mode_q <= par_mode_d;
            par_bit_q  <= par_bit_d;
            baud_q     <= baud_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TxD     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8-bit/1-stop and 16-bit/2-stop builds, decoded from TxD.
module tb_uart_tx_param;

    localparam int BIT7 = 432;   // 16 * 27 cycles at 115200
    localparam int BIT5 = 1296;  // 16 * 81 cycles at 38400

    logic clk = 1'b0;
    logic reset;

    logic [2:0]  baud_a, baud_b;
    logic [1:0]  par_a, par_b;
    logic        tx_en_a, tx_en_b, tx_valid_a, tx_valid_b;
    logic [7:0]  tx_data_a;
    logic [15:0] tx_data_b;
    logic        ready_a, busy_a, done_a, txd_a;
    logic        ready_b, busy_b, done_b, txd_b;

    int cyc = 0;
    int acc_cnt_a = 0, acc_cyc_a = 0, acc_cnt_b = 0, acc_cyc_b = 0;
    int n_vec = 0, n_miss = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_W(8), .STOP_BITS(1), .OVERSAMPLE(16)) u_dut_a (
        .clk(clk), .reset(reset), .baud_select(baud_a), .parity_mode(par_a),
        .tx_en(tx_en_a), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
        .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .TxD(txd_a)
    );

    uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_W(16), .STOP_BITS(2), .OVERSAMPLE(16)) u_dut_b (
        .clk(clk), .reset(reset), .baud_select(baud_b), .parity_mode(par_b),
        .tx_en(tx_en_b), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
        .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .TxD(txd_b)
    );

    // Cycle counter and acceptance monitor (edge index of each handshake).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid_a && ready_a) begin
            acc_cnt_a <= acc_cnt_a + 1;
            acc_cyc_a <= cyc + 1;
        end
        if (tx_valid_b && ready_b) begin
            acc_cnt_b <= acc_cnt_b + 1;
            acc_cyc_b <= cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic txd_of(input int sel);
        return (sel != 0) ? txd_b : txd_a;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel != 0) ? done_b : done_a;
    endfunction

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic [2:0] bs, input logic [1:0] pm);
        int n0;
        int g;
        n0 = acc_cnt_a;
        g  = 0;
        tx_data_a = d; baud_a = bs; par_a = pm; tx_valid_a = 1'b1;
        while (acc_cnt_a == n0 && g < 20000) begin @(negedge clk); g++; end
        tx_valid_a = 1'b0;
        chk("accept_a", 32'(g < 20000), 32'd1);
    endtask

    // Decode one frame from TxD by mid-bit sampling and check its timing.
    task automatic rx_frame(input int sel, input logic [15:0] exp, input int nbits,
                            input bit par_en, input logic exp_p, input int stops,
                            input int bitc, output int t_start, output int t_done);
        int g;
        int total;
        int base;
        logic [15:0] got;
        got   = '0;
        g     = 0;
        total = 1 + nbits + (par_en ? 1 : 0) + stops;
        while (txd_of(sel) && g < 30000) begin @(negedge clk); g++; end
        chk("start_seen", 32'(g < 30000), 32'd1);
        t_start = cyc;
        wait_to(t_start + bitc / 2);
        chk("start_bit", 32'(txd_of(sel)), 32'd0);
        chk("busy_mid", 32'(busy_of(sel)), 32'd1);
        wait_to(t_start + bitc - 1);
        chk("start_len", 32'(txd_of(sel)), 32'd0);
        for (int k = 0; k < nbits; k++) begin
            wait_to(t_start + (k + 1) * bitc + bitc / 2);
            got[k] = txd_of(sel);
        end
        chk("data", 32'(got), 32'(exp));
        if (par_en) begin
            wait_to(t_start + (nbits + 1) * bitc + bitc / 2);
            chk("parity", 32'(txd_of(sel)), 32'(exp_p));
        end
        for (int s = 0; s < stops; s++) begin
            base = 1 + nbits + (par_en ? 1 : 0) + s;
            wait_to(t_start + base * bitc + bitc / 2);
            chk("stop", 32'(txd_of(sel)), 32'd1);
        end
        g = 0;
        while (!done_of(sel) && g < 2 * bitc) begin @(negedge clk); g++; end
        t_done = cyc;
        chk("done_time", 32'(t_done - t_start), 32'(total * bitc));
        chk("busy_fall", 32'(busy_of(sel)), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done_of(sel)), 32'd0);
    endtask

    initial begin
        int ts, td, ts2, td2, n0, g1;
        reset = 1'b1;
        baud_a = 3'd7; par_a = 2'b00; tx_en_a = 1'b1; tx_valid_a = 1'b0; tx_data_a = '0;
        baud_b = 3'd5; par_b = 2'b00; tx_en_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = '0;
        repeat (3) @(negedge clk);

        // Reset state, with tx_en already high.
        chk("rst_txd", 32'(txd_a), 32'd1);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_idle", 32'(ready_a), 32'd1);

        // 8N1 0x55 at 115200: start one edge after acceptance.
        send_a(8'h55, 3'd7, 2'b00);
        rx_frame(0, 16'h0055, 8, 1'b0, 1'b0, 1, BIT7, ts, td);
        chk("start_latency", 32'(ts - acc_cyc_a), 32'd1);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        send_a(8'h07, 3'd7, 2'b01);
        rx_frame(0, 16'h0007, 8, 1'b1, 1'b1, 1, BIT7, ts, td);
        send_a(8'h07, 3'd7, 2'b10);
        rx_frame(0, 16'h0007, 8, 1'b1, 1'b0, 1, BIT7, ts, td);

        // Back-to-back with tx_valid held: accept on the edge after tx_done, start bit on the next.
        n0 = acc_cnt_a;
        fork
            begin
                g1 = 0;
                tx_data_a = 8'hA3; baud_a = 3'd7; par_a = 2'b00; tx_valid_a = 1'b1;
                while (acc_cnt_a == n0 && g1 < 20000) begin @(negedge clk); g1++; end
                tx_data_a = 8'h3C;
                while (acc_cnt_a == n0 + 1 && g1 < 20000) begin @(negedge clk); g1++; end
                tx_valid_a = 1'b0;
            end
            begin
                rx_frame(0, 16'h00A3, 8, 1'b0, 1'b0, 1, BIT7, ts, td);
                rx_frame(0, 16'h003C, 8, 1'b0, 1'b0, 1, BIT7, ts2, td2);
            end
        join
        chk("b2b_accepts", 32'(acc_cnt_a - n0), 32'd2);
        chk("b2b_accept_cyc", 32'(acc_cyc_a - td), 32'd1);
        chk("b2b_gap", 32'(ts2 - td), 32'd2);

        // Mid-frame baud/parity/tx_en changes and a stray valid: frame unchanged, nothing new taken.
        send_a(8'h5A, 3'd7, 2'b00);
        n0 = acc_cnt_a;
        fork
            rx_frame(0, 16'h005A, 8, 1'b0, 1'b0, 1, BIT7, ts, td);
            begin
                wait_to(acc_cyc_a + 1 + 3 * BIT7 + 50);
                baud_a = 3'd0; par_a = 2'b01; tx_en_a = 1'b0;
                tx_data_a = 8'hFF; tx_valid_a = 1'b1;
            end
        join
        repeat (500) @(negedge clk);
        chk("en_off_accepts", 32'(acc_cnt_a - n0), 32'd0);
        chk("en_off_busy", 32'(busy_a), 32'd0);
        chk("en_off_ready", 32'(ready_a), 32'd0);
        chk("en_off_txd", 32'(txd_a), 32'd1);
        tx_valid_a = 1'b0; tx_en_a = 1'b1;
        @(negedge clk);

        // Reset during a data bit clears the line on the next edge; next word is clean.
        send_a(8'h96, 3'd7, 2'b00);
        wait_to(acc_cyc_a + 1 + 3 * BIT7 + 100);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_txd", 32'(txd_a), 32'd1);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_ready", 32'(ready_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        send_a(8'hC3, 3'd7, 2'b10);
        rx_frame(0, 16'h00C3, 8, 1'b1, 1'b1, 1, BIT7, ts, td);

        // 16-bit, 2-stop build at 38400: 19 bits of 1296 cycles.
        n0 = acc_cnt_b;
        g1 = 0;
        tx_data_b = 16'h3333; tx_valid_b = 1'b1;
        while (acc_cnt_b == n0 && g1 < 20000) begin @(negedge clk); g1++; end
        tx_valid_b = 1'b0;
        chk("accept_b", 32'(g1 < 20000), 32'd1);
        rx_frame(1, 16'h3333, 16, 1'b0, 1'b0, 2, BIT5, ts, td);
        chk("start_latency_b", 32'(ts - acc_cyc_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
